// File: rtl/inst_cache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package inst_cache_pkg;

  localparam int REG_BUS       = 32;
  localparam int INST_ADDR_BUS = 32;
  localparam int LINE_WORDS    = 4;
  localparam int WORD_OFF_W    = 2;
  localparam int BYTE_OFF_W    = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;

  typedef logic [REG_BUS-1:0]       word_t;
  typedef logic [INST_ADDR_BUS-1:0] addr_t;

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled.
interface inst_cache_if;
  import inst_cache_pkg::*;

  logic  ce_i;
  addr_t addr_i;
  logic  flush_i;
  word_t data_o;
  logic  stallreq_o;
  logic  mem_req_o;
  addr_t mem_addr_o;
  word_t mem_data_i;
  logic  mem_ack_i;

  modport slave (
    input  ce_i, addr_i, flush_i, mem_data_i, mem_ack_i,
    output data_o, stallreq_o, mem_req_o, mem_addr_o
  );

  modport master (
    output ce_i, addr_i, flush_i, mem_data_i, mem_ack_i,
    input  data_o, stallreq_o, mem_req_o, mem_addr_o
  );

endinterface

// File: rtl/inst_cache_line_ram.sv
// Cache data array: LINES x 4 words, asynchronous read, synchronous write, no reset.
module inst_cache_line_ram
  import inst_cache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int INDEX_BITS = 4
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [INDEX_BITS+WORD_OFF_W-1:0] waddr_i,
  input  word_t                        wdata_i,
  input  logic [INDEX_BITS+WORD_OFF_W-1:0] raddr_i,
  output word_t                        rdata_o
);

  word_t mem_q [LINES*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: combinational hit path, 4-word line refill
// over a req/ack memory port, flush invalidates all lines and aborts a refill.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int INDEX_BITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  inst_cache_if.slave  bus
);

  localparam int OFF_BITS = WORD_OFF_W + BYTE_OFF_W;
  localparam int TAG_BITS = INST_ADDR_BUS - OFF_BITS - INDEX_BITS;

  logic [TAG_BITS-1:0]   tag_w;
  logic [INDEX_BITS-1:0] index_w;
  logic [WORD_OFF_W-1:0] word_w;
  logic                  unused_byte_off;

  assign tag_w           = bus.addr_i[INST_ADDR_BUS-1 -: TAG_BITS];
  assign index_w         = bus.addr_i[OFF_BITS+INDEX_BITS-1:OFF_BITS];
  assign word_w          = bus.addr_i[OFF_BITS-1:BYTE_OFF_W];
  assign unused_byte_off = ^bus.addr_i[BYTE_OFF_W-1:0];

  logic [1:0]            state_q, state_d;
  logic [WORD_OFF_W-1:0] cnt_q, cnt_d;
  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0] miss_index_q, miss_index_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q [LINES];

  logic  refill;
  logic  hit;
  logic  ack_w;
  logic  ram_we;
  logic  tag_we;
  word_t ram_rdata;

  assign refill = (state_q == ST_REFILL);
  // A flush in progress makes every lookup miss, even for a line still marked valid.
  assign hit    = valid_q[index_w] && (tag_q[index_w] == tag_w) && !bus.flush_i;
  assign ack_w  = refill && bus.mem_ack_i;
  assign ram_we = ack_w && !bus.flush_i;
  assign tag_we = ram_we && (cnt_q == 2'd3);

  inst_cache_line_ram #(
    .LINES      (LINES),
    .INDEX_BITS (INDEX_BITS)
  ) u_line_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i ({miss_index_q, cnt_q}),
    .wdata_i (bus.mem_data_i),
    .raddr_i ({index_w, word_w}),
    .rdata_o (ram_rdata)
  );

  word_t data_w;
  logic  stall_w;
  logic  req_w;
  addr_t maddr_w;

  always_comb begin
    data_w  = '0;
    stall_w = 1'b0;
    req_w   = 1'b0;
    maddr_w = '0;
    if (!rst) begin
      if (refill) begin
        stall_w = 1'b1;
        req_w   = 1'b1;
        maddr_w = {miss_tag_q, miss_index_q, cnt_q, 2'b00};
      end else if (bus.ce_i) begin
        if (hit) begin
          data_w = ram_rdata;
        end else begin
          stall_w = 1'b1;
        end
      end
    end
  end

  assign bus.data_o     = data_w;
  assign bus.stallreq_o = stall_w;
  assign bus.mem_req_o  = req_w;
  assign bus.mem_addr_o = maddr_w;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    valid_d      = valid_q;
    if (bus.flush_i) begin
      valid_d = '0;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_IDLE) begin
      if (bus.ce_i && !hit) begin
        miss_tag_d   = tag_w;
        miss_index_d = index_w;
        cnt_d        = '0;
        state_d      = ST_REFILL;
      end
    end else if (ack_w) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        valid_d[miss_index_q] = 1'b1;
        state_d               = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[miss_index_q] <= miss_tag_q;
    end
  end

endmodule
